// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the core load/store
// path. One request at a time, WAIT wait states, byte/half/word access.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_ready  request handshake (ready only when idle)
//   req_write            1 = store, 0 = load
//   req_addr             byte address (ADDR_W bits)
//   req_funct3           RV32I width code
//   req_wdata            store data, right-aligned
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata            extended load data, 0 for stores and errors
//   rsp_err              request faulted
//   busy                 transaction in flight
//
// Build option: define DMEM_MISALIGN_TRAP_EN to fault misaligned half/word
// accesses; otherwise they are forced aligned.
module dmem_responder #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 64,
    parameter int WAIT   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state, state_nx;
    logic [3:0] wcnt;

    logic              lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [2:0]        lat_f3;
    logic [31:0]       lat_wdata;

    logic accept, access;

    logic [31:0] mem [DEPTH];

    // With WAIT=0 the access happens on the accepting edge, so the access
    // path reads the live request instead of the latched copy while idle.
    logic              a_write;
    logic [ADDR_W-1:0] a_addr;
    logic [2:0]        a_f3;
    logic [31:0]       a_wdata;

    logic [31:0] idx_w;
    logic        in_range;
    logic [31:0] word;
    logic [1:0]  lane;
    logic        is_b, is_h, is_w, uns, f3_bad;
    logic        bad_op, mis, acc_err;
    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] ld_data;
    logic [31:0] acc_rdata;
    logic [3:0]  wmask;
    logic [31:0] wword;
    logic        we;

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign busy      = (state != S_IDLE);

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        access   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT == 0) begin
                        access   = 1'b1;
                        state_nx = S_RESP;
                    end else begin
                        state_nx = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (wcnt == 4'd1) begin
                    access   = 1'b1;
                    state_nx = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign a_write = (state == S_IDLE) ? req_write  : lat_write;
    assign a_addr  = (state == S_IDLE) ? req_addr   : lat_addr;
    assign a_f3    = (state == S_IDLE) ? req_funct3 : lat_f3;
    assign a_wdata = (state == S_IDLE) ? req_wdata  : lat_wdata;

    assign idx_w    = 32'(a_addr[ADDR_W-1:2]);
    assign in_range = idx_w < 32'(DEPTH);
    assign word     = in_range ? mem[idx_w[AW-1:0]] : 32'd0;
    assign lane     = a_addr[1:0];

    always_comb begin
        is_b   = 1'b0;
        is_h   = 1'b0;
        is_w   = 1'b0;
        uns    = 1'b0;
        f3_bad = 1'b0;
        case (a_f3)
            3'b000:  is_b = 1'b1;
            3'b001:  is_h = 1'b1;
            3'b010:  is_w = 1'b1;
            3'b100: begin
                is_b = 1'b1;
                uns  = 1'b1;
            end
            3'b101: begin
                is_h = 1'b1;
                uns  = 1'b1;
            end
            default: f3_bad = 1'b1;
        endcase
    end

    // Unsigned codes have no store form.
    assign bad_op = f3_bad || (a_write && uns);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign mis = (is_h && lane[0]) || (is_w && (lane != 2'b00));
`else
    assign mis = 1'b0;
`endif

    assign acc_err = !in_range || bad_op || mis;

    assign shifted = word >> {lane, 3'b000};
    assign byte_v  = shifted[7:0];
    assign half_v  = lane[1] ? word[31:16] : word[15:0];

    always_comb begin
        ld_data = word;
        if (is_b) ld_data = {{24{byte_v[7] & ~uns}}, byte_v};
        else if (is_h) ld_data = {{16{half_v[15] & ~uns}}, half_v};
    end

    assign acc_rdata = (acc_err || a_write) ? 32'd0 : ld_data;

    always_comb begin
        wmask = 4'b0000;
        wword = a_wdata;
        if (is_b) begin
            wmask = 4'b0001 << lane;
            wword = {4{a_wdata[7:0]}};
        end else if (is_h) begin
            wmask = lane[1] ? 4'b1100 : 4'b0011;
            wword = {2{a_wdata[15:0]}};
        end else if (is_w) begin
            wmask = 4'b1111;
        end
    end

    assign we = access && a_write && !acc_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wcnt      <= 4'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_f3    <= 3'd0;
            lat_wdata <= 32'd0;
        end else begin
            state <= state_nx;
            if (accept) begin
                lat_write <= req_write;
                lat_addr  <= req_addr;
                lat_f3    <= req_funct3;
                lat_wdata <= req_wdata;
                wcnt      <= 4'(WAIT);
            end else if (state == S_WAIT) begin
                wcnt <= wcnt - 4'd1;
            end
            if (access) begin
                rsp_rdata <= acc_rdata;
                rsp_err   <= acc_err;
            end
        end
    end

    // Memory contents survive reset; only an in-flight commit is dropped.
    always_ff @(posedge clk) begin
        if (!rst && we) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) mem[idx_w[AW-1:0]][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and randomized bench for dmem_responder.
// Random traffic is checked against a byte-array style reference model.
module tb_dmem_responder;

    localparam int AW    = 9;
    localparam int DEPTH = 64;
    localparam int WAIT  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [2:0]    req_funct3;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ref_mem [DEPTH];

    always #5 clk = ~clk;

    dmem_responder #(
        .ADDR_W (AW),
        .DEPTH  (DEPTH),
        .WAIT   (WAIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    // Reference: treat the word as 4 little-endian bytes, pick nb bytes at
    // offset off, extend arithmetically.
    function automatic void model(input bit wr, input logic [AW-1:0] a,
                                  input logic [2:0] f3, input logic [31:0] wd,
                                  output logic [31:0] rd, output bit er);
        int idx, off, nb;
        bit sgn_free;
        logic [31:0] mask, v;
        idx = int'(a) / 4;
        off = int'(a) % 4;
        sgn_free = 1'b0;
        nb = 0;
        rd = 32'd0;
        er = 1'b0;
        case (f3)
            3'd0: nb = 1;
            3'd1: nb = 2;
            3'd2: nb = 4;
            3'd4: begin nb = 1; sgn_free = 1'b1; end
            3'd5: begin nb = 2; sgn_free = 1'b1; end
            default: nb = 0;
        endcase
        if (nb == 0 || (wr && sgn_free) || idx >= DEPTH) er = 1'b1;
        if (nb != 0) begin
`ifdef DMEM_MISALIGN_TRAP_EN
            if (off % nb != 0) er = 1'b1;
`else
            off = off - (off % nb);
`endif
        end
        if (er) return;
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        if (wr) begin
            ref_mem[idx] = (ref_mem[idx] & ~(mask << (8 * off)))
                         | ((wd & mask) << (8 * off));
        end else begin
            v = (ref_mem[idx] >> (8 * off)) & mask;
            if (!sgn_free && nb < 4 && v >= (32'd1 << (8 * nb - 1)))
                v = v - (32'd1 << (8 * nb));
            rd = v;
        end
    endfunction

    task automatic send_req(input bit wr, input logic [AW-1:0] a,
                            input logic [2:0] f3, input logic [31:0] wd);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        req_write  = wr;
        req_addr   = a;
        req_funct3 = f3;
        req_wdata  = wd;
        req_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_write  = 1'($urandom);
        req_addr   = AW'($urandom);
        req_funct3 = 3'($urandom);
        req_wdata  = $urandom;
    endtask

    // lat = edges after the accepting edge before rsp_valid is seen.
    task automatic wait_rsp(output int lat);
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic ack_rsp(output bit vld_after, output bit rdy_after);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        vld_after = rsp_valid;
        rdy_after = req_ready;
    endtask

    task automatic txn(input bit wr, input logic [AW-1:0] a,
                       input logic [2:0] f3, input logic [31:0] wd,
                       input int hold, output int lat,
                       output logic [31:0] rd, output bit er);
        bit v, r;
        send_req(wr, a, f3, wd);
        wait_rsp(lat);
        repeat (hold) @(negedge clk);
        rd = rsp_rdata;
        er = rsp_err;
        ack_rsp(v, r);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_err, busy} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 1000",
                     {req_ready, rsp_valid, rsp_err, busy});
        end
        n_checks++;
        if (rsp_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_rdata got %h want 0", rsp_rdata);
        end
    endtask

    task automatic test_word;
        int lat;
        logic [31:0] rd;
        bit er, v, r;
        send_req(1'b1, 9'h010, 3'b010, 32'hDEAD_BEEF);
        wait_rsp(lat);
        n_checks++;
        if (lat !== WAIT) begin
            n_fail++;
            $display("FAIL sw_latency got %0d want %0d", lat, WAIT);
        end
        n_checks++;
        if ({busy, req_ready, rsp_err} !== 3'b100 || rsp_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL sw_resp got busy/rdy/err %b rdata %h want 100 0",
                     {busy, req_ready, rsp_err}, rsp_rdata);
        end
        ack_rsp(v, r);
        n_checks++;
        if ({v, r} !== 2'b01) begin
            n_fail++;
            $display("FAIL sw_ack got vld/rdy %b want 01", {v, r});
        end
        txn(1'b0, 9'h010, 3'b010, 32'd0, 0, lat, rd, er);
        n_checks++;
        if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_word got %h/%b want deadbeef/0", rd, er);
        end
    endtask

    task automatic test_extend;
        logic [AW-1:0] ta [4] = '{9'h020, 9'h020, 9'h022, 9'h022};
        logic [2:0]    tf [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0]   te [4] = '{32'hFFFF_FF80, 32'h0000_0080,
                                  32'hFFFF_8001, 32'h0000_8001};
        int lat;
        logic [31:0] rd;
        bit er;
        txn(1'b1, 9'h020, 3'b010, 32'h8001_F080, 0, lat, rd, er);
        for (int i = 0; i < 4; i++) begin
            txn(1'b0, ta[i], tf[i], 32'd0, 0, lat, rd, er);
            n_checks++;
            if (rd !== te[i] || er !== 1'b0) begin
                n_fail++;
                $display("FAIL extend_%0d got %h/%b want %h/0", i, rd, er, te[i]);
            end
        end
    endtask

    task automatic test_partial;
        int lat;
        logic [31:0] rd;
        bit er;
        txn(1'b1, 9'h004, 3'b010, 32'h1122_3344, 0, lat, rd, er);
        txn(1'b1, 9'h005, 3'b000, 32'hFFFF_FFAA, 0, lat, rd, er);
        txn(1'b0, 9'h004, 3'b010, 32'd0, 0, lat, rd, er);
        n_checks++;
        if (rd !== 32'h1122_AA44) begin
            n_fail++;
            $display("FAIL sb_merge got %h want 1122aa44", rd);
        end
        txn(1'b1, 9'h006, 3'b001, 32'h1234_BEEF, 0, lat, rd, er);
        txn(1'b0, 9'h004, 3'b010, 32'd0, 0, lat, rd, er);
        n_checks++;
        if (rd !== 32'hBEEF_AA44) begin
            n_fail++;
            $display("FAIL sh_merge got %h want beefaa44", rd);
        end
    endtask

    task automatic test_backpressure;
        int lat;
        logic [31:0] rd;
        bit er, v, r;
        send_req(1'b0, 9'h020, 3'b010, 32'd0);
        wait_rsp(lat);
        req_write  = 1'b1;
        req_addr   = 9'h010;
        req_funct3 = 3'b010;
        req_wdata  = 32'h0BAD_0BAD;
        req_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({rsp_valid, req_ready} !== 2'b10 || rsp_rdata !== 32'h8001_F080) begin
                n_fail++;
                $display("FAIL hold_%0d got vld/rdy %b rdata %h want 10 8001f080",
                         i, {rsp_valid, req_ready}, rsp_rdata);
            end
        end
        req_valid = 1'b0;
        ack_rsp(v, r);
        n_checks++;
        if ({v, r} !== 2'b01) begin
            n_fail++;
            $display("FAIL hold_release got vld/rdy %b want 01", {v, r});
        end
        txn(1'b0, 9'h010, 3'b010, 32'd0, 0, lat, rd, er);
        n_checks++;
        if (rd !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL ignored_req got %h want deadbeef", rd);
        end
    endtask

    task automatic test_errors;
        int lat;
        logic [31:0] rd;
        bit er;
        txn(1'b0, 9'h100, 3'b010, 32'd0, 0, lat, rd, er);
        n_checks++;
        if ({er, rd} !== {1'b1, 32'd0}) begin
            n_fail++;
            $display("FAIL oob_load got %b/%h want 1/0", er, rd);
        end
        txn(1'b0, 9'h010, 3'b011, 32'd0, 0, lat, rd, er);
        n_checks++;
        if ({er, rd} !== {1'b1, 32'd0}) begin
            n_fail++;
            $display("FAIL f3_011 got %b/%h want 1/0", er, rd);
        end
        txn(1'b1, 9'h010, 3'b111, 32'h1111_1111, 0, lat, rd, er);
        n_checks++;
        if (er !== 1'b1) begin
            n_fail++;
            $display("FAIL store_f3_111 got %b want 1", er);
        end
        txn(1'b1, 9'h010, 3'b100, 32'h2222_2222, 0, lat, rd, er);
        n_checks++;
        if (er !== 1'b1) begin
            n_fail++;
            $display("FAIL store_f3_100 got %b want 1", er);
        end
        txn(1'b0, 9'h010, 3'b010, 32'd0, 0, lat, rd, er);
        n_checks++;
        if (rd !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL err_nowrite got %h want deadbeef", rd);
        end
        txn(1'b1, 9'h000, 3'b010, 32'h0BAD_F00D, 0, lat, rd, er);
        txn(1'b0, 9'h002, 3'b010, 32'd0, 0, lat, rd, er);
        n_checks++;
`ifdef DMEM_MISALIGN_TRAP_EN
        if ({er, rd} !== {1'b1, 32'd0}) begin
            n_fail++;
            $display("FAIL lw_misalign got %b/%h want 1/0", er, rd);
        end
`else
        if ({er, rd} !== {1'b0, 32'h0BAD_F00D}) begin
            n_fail++;
            $display("FAIL lw_misalign got %b/%h want 0/0badf00d", er, rd);
        end
`endif
        txn(1'b0, 9'h021, 3'b001, 32'd0, 0, lat, rd, er);
        n_checks++;
`ifdef DMEM_MISALIGN_TRAP_EN
        if ({er, rd} !== {1'b1, 32'd0}) begin
            n_fail++;
            $display("FAIL lh_misalign got %b/%h want 1/0", er, rd);
        end
`else
        if ({er, rd} !== {1'b0, 32'hFFFF_F080}) begin
            n_fail++;
            $display("FAIL lh_misalign got %b/%h want 0/fffff080", er, rd);
        end
`endif
    endtask

    task automatic test_reset_mid;
        int lat;
        logic [31:0] rd;
        bit er, seen;
        txn(1'b1, 9'h030, 3'b010, 32'hCAFE_F00D, 0, lat, rd, er);
        send_req(1'b1, 9'h030, 3'b010, 32'h1234_5678);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid got seen %b rdy %b want 0 1", seen, req_ready);
        end
        txn(1'b0, 9'h030, 3'b010, 32'd0, 0, lat, rd, er);
        n_checks++;
        if (rd !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL rst_discard got %h want cafef00d", rd);
        end
    endtask

    task automatic test_back_to_back;
        int cyc, n;
        int acc [4];
        n = 0;
        cyc = 0;
        @(negedge clk);
        req_write  = 1'b0;
        req_addr   = 9'h010;
        req_funct3 = 3'b010;
        req_valid  = 1'b1;
        rsp_ready  = 1'b1;
        for (int i = 0; i < 30 && n < 4; i++) begin
            if (req_ready) begin
                acc[n] = cyc;
                n++;
            end
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b0;
        repeat (WAIT + 3) @(negedge clk);
        rsp_ready = 1'b0;
        n_checks++;
        if (n !== 4) begin
            n_fail++;
            $display("FAIL b2b_count got %0d want 4", n);
        end else begin
            for (int i = 1; i < 4; i++) begin
                n_checks++;
                if (acc[i] - acc[i-1] !== WAIT + 2) begin
                    n_fail++;
                    $display("FAIL b2b_gap_%0d got %0d want %0d",
                             i, acc[i] - acc[i-1], WAIT + 2);
                end
            end
        end
    endtask

    task automatic test_random;
        logic [2:0] good [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        int lat;
        logic [31:0] rd, erd, wd;
        bit er, eer, wr;
        logic [AW-1:0] a;
        logic [2:0] f3;
        for (int i = 0; i < DEPTH; i++) begin
            wd = $urandom;
            model(1'b1, AW'(4 * i), 3'b010, wd, erd, eer);
            txn(1'b1, AW'(4 * i), 3'b010, wd, 0, lat, rd, er);
        end
        for (int i = 0; i < 200; i++) begin
            wr = 1'($urandom);
            a = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(256, 511))
                                            : AW'($urandom_range(0, 255));
            f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom)
                                             : good[$urandom_range(0, 4)];
            wd = $urandom;
            model(wr, a, f3, wd, erd, eer);
            txn(wr, a, f3, wd, $urandom_range(0, 2), lat, rd, er);
            n_checks++;
            if (lat !== WAIT || rd !== erd || er !== eer) begin
                n_fail++;
                $display("FAIL rand_%0d wr %b a %h f3 %b got lat %0d %h/%b want %0d %h/%b",
                         i, wr, a, f3, lat, rd, er, WAIT, erd, eer);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_funct3 = 3'd0;
        req_wdata  = 32'd0;
        rsp_ready  = 1'b0;
        test_reset;
        test_word;
        test_extend;
        test_partial;
        test_backpressure;
        test_errors;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
